multi_cycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. In every state it drives the datapath enables and the 3-bit ALUOp code consumed by the ALU control decoder. Memory accesses use a ready handshake, so wait states are absorbed here.

---
 rtl/multi_cycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle datapath: IF/ID/EX/MEM/WB sequencing with ready handshake.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP instead of retiring as a NOP.
module multi_cycle_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [5:0]        instr_op_i,
    input  logic              zero_i,
    input  logic              mem_ready_i,
    output logic [2:0]        ALUOp_o,
    output logic              alu_src_o,
    output logic              reg_dst_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              iord_o,
    output logic              mem_to_reg_o,
    output logic              ir_write_o,
    output logic              pc_write_o,
    output logic              pc_src_o,
    output logic              retire_o,
    output logic [ADDR_W-1:0] retire_cnt_o,
    output logic              illegal_o
);

    localparam logic [5:0] OpR     = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
        , StTrap = 3'd5
`endif
    } state_e;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;

    logic is_r, is_addi, is_sltiu, is_ori, is_lui, is_beq, is_bne, is_lw, is_sw;
    logic known, is_branch, is_ls;
    logic [2:0] alu_class;

    assign is_r      = (instr_op_i == OpR);
    assign is_addi   = (instr_op_i == OpAddi);
    assign is_sltiu  = (instr_op_i == OpSltiu);
    assign is_ori    = (instr_op_i == OpOri);
    assign is_lui    = (instr_op_i == OpLui);
    assign is_beq    = (instr_op_i == OpBeq);
    assign is_bne    = (instr_op_i == OpBne);
    assign is_lw     = (instr_op_i == OpLw);
    assign is_sw     = (instr_op_i == OpSw);
    assign is_branch = is_beq | is_bne;
    assign is_ls     = is_lw | is_sw;
    assign known     = is_r | is_addi | is_sltiu | is_ori | is_lui | is_branch | is_ls;

    always_comb begin
        alu_class = 3'd0;
        if (is_addi || is_ls) alu_class = 3'd1;
        if (is_sltiu)         alu_class = 3'd2;
        if (is_beq)           alu_class = 3'd3;
        if (is_lui)           alu_class = 3'd4;
        if (is_ori)           alu_class = 3'd5;
        if (is_bne)           alu_class = 3'd6;
    end

    logic [2:0] alu_op_c;
    logic alu_src_c, reg_dst_c, reg_write_c, mem_read_c, mem_write_c, iord_c;
    logic mem_to_reg_c, ir_write_c, pc_write_c, pc_src_c, retire_c, illegal_c;

    always_comb begin
        state_d      = state_q;
        alu_op_c     = 3'd0;
        alu_src_c    = 1'b0;
        reg_dst_c    = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        mem_to_reg_c = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        retire_c     = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            StIf: begin
                mem_read_c = 1'b1;
                if (mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = StId;
                end
            end
            StId: begin
                if (known) begin
                    state_d = StEx;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    // Unknown opcode retires as a NOP.
                    illegal_c = 1'b1;
                    retire_c  = 1'b1;
                    state_d   = StIf;
`endif
                end
            end
            StEx: begin
                alu_op_c  = alu_class;
                alu_src_c = ~(is_r | is_branch);
                if (is_branch) begin
                    pc_src_c   = 1'b1;
                    pc_write_c = (is_beq & zero_i) | (is_bne & ~zero_i);
                    retire_c   = 1'b1;
                    state_d    = StIf;
                end else if (is_ls) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                iord_c      = 1'b1;
                mem_read_c  = is_lw;
                mem_write_c = is_sw;
                if (mem_ready_i) begin
                    if (is_lw) begin
                        state_d = StWb;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = StIf;
                    end
                end
            end
            StWb: begin
                alu_op_c     = alu_class;
                reg_write_c  = 1'b1;
                reg_dst_c    = is_r;
                mem_to_reg_c = is_lw;
                retire_c     = 1'b1;
                state_d      = StIf;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            StTrap: illegal_c = 1'b1;
`endif
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    // Reset masks every output so an in-flight memory request drops immediately.
    assign ALUOp_o      = rst_n ? alu_op_c : 3'd0;
    assign alu_src_o    = rst_n & alu_src_c;
    assign reg_dst_o    = rst_n & reg_dst_c;
    assign reg_write_o  = rst_n & reg_write_c;
    assign mem_read_o   = rst_n & mem_read_c;
    assign mem_write_o  = rst_n & mem_write_c;
    assign iord_o       = rst_n & iord_c;
    assign mem_to_reg_o = rst_n & mem_to_reg_c;
    assign ir_write_o   = rst_n & ir_write_c;
    assign pc_write_o   = rst_n & pc_write_c;
    assign pc_src_o     = rst_n & pc_src_c;
    assign retire_o     = rst_n & retire_c;
    assign illegal_o    = rst_n & illegal_c;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: vector table of instruction latencies, hand-written reset/wrap/trap
// sequences and randomized instruction streams checked cycle by cycle against a phase-list model.
module tb_multi_cycle_ctrl;

    localparam int unsigned AW = 4;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    localparam int PH_IF = 0, PH_ID = 1, PH_EX = 2, PH_MEM = 3, PH_WB = 4, PH_TRAP = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    instr_op;
    logic          zero, mem_ready;
    logic [2:0]    alu_op;
    logic          alu_src, reg_dst, reg_write, mem_read, mem_write, iord;
    logic          mem_to_reg, ir_write, pc_write, pc_src, retire, illegal;
    logic [AW-1:0] retire_cnt;
    logic [14:0]   dut_v;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] cnt_m;
    int cur_n, first_ret;

    multi_cycle_ctrl #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_n(rst_n), .instr_op_i(instr_op), .zero_i(zero),
        .mem_ready_i(mem_ready), .ALUOp_o(alu_op), .alu_src_o(alu_src), .reg_dst_o(reg_dst),
        .reg_write_o(reg_write), .mem_read_o(mem_read), .mem_write_o(mem_write), .iord_o(iord),
        .mem_to_reg_o(mem_to_reg), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .pc_src_o(pc_src), .retire_o(retire), .retire_cnt_o(retire_cnt), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    assign dut_v = {alu_op, alu_src, reg_dst, reg_write, mem_read, mem_write, iord,
                    mem_to_reg, ir_write, pc_write, pc_src, retire, illegal};

    function automatic int cls(logic [5:0] op);
        case (op)
            OP_R:                 return 0;
            OP_ADDI, OP_LW, OP_SW: return 1;
            OP_SLTIU:             return 2;
            OP_BEQ:               return 3;
            OP_LUI:               return 4;
            OP_ORI:               return 5;
            OP_BNE:               return 6;
            default:              return -1;
        endcase
    endfunction

    // Expected output vector for one cycle of a given instruction phase.
    function automatic logic [14:0] exp_out(int ph, logic [5:0] op, logic z, logic rdy);
        logic [2:0] aop;
        logic asrc, rdst, rw, mr, mw, io, m2r, irw, pcw, pcs, ret, ill;
        bit br, lw, sw;
        aop = 3'd0; {asrc, rdst, rw, mr, mw, io, m2r, irw, pcw, pcs, ret, ill} = 12'd0;
        br = (op == OP_BEQ) || (op == OP_BNE);
        lw = (op == OP_LW);
        sw = (op == OP_SW);
        case (ph)
            PH_IF: begin mr = 1'b1; irw = rdy; pcw = rdy; end
            PH_ID: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
                if (cls(op) < 0) begin ill = 1'b1; ret = 1'b1; end
`endif
            end
            PH_EX: begin
                aop  = 3'(cls(op));
                asrc = !(op == OP_R || br);
                if (br) begin
                    pcs = 1'b1;
                    pcw = (op == OP_BEQ) ? z : !z;
                    ret = 1'b1;
                end
            end
            PH_MEM: begin io = 1'b1; mr = lw; mw = sw; ret = sw && rdy; end
            PH_WB: begin
                aop = 3'(cls(op)); rw = 1'b1; rdst = (op == OP_R); m2r = lw; ret = 1'b1;
            end
            PH_TRAP: ill = 1'b1;
            default: ;
        endcase
        return {aop, asrc, rdst, rw, mr, mw, io, m2r, irw, pcw, pcs, ret, ill};
    endfunction

    task automatic check_vec(string tag, logic [14:0] got, logic [14:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: outputs got %h required %h", tag, got, want);
        end
    endtask

    task automatic check_int(string tag, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", tag, got, want);
        end
    endtask

    task automatic step(int ph, logic [5:0] op, logic z, logic rdy, string tag);
        logic [14:0] e;
        @(negedge clk);
        instr_op = op; zero = z; mem_ready = rdy;
        #2;
        e = exp_out(ph, op, z, rdy);
        check_vec($sformatf("%s ph%0d", tag, ph), dut_v, e);
        check_int($sformatf("%s cnt", tag), int'(retire_cnt), int'(cnt_m));
        cur_n++;
        if (retire === 1'b1 && first_ret < 0) first_ret = cur_n;
        if (e[1]) cnt_m = cnt_m + 1'b1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one whole instruction; returns the cycle index at which the DUT pulsed retire.
    task automatic run_instr(logic [5:0] op, logic z, int if_w, int mem_w, string tag,
                             output int dut_cycles);
        bit br, ls, lw;
        br = (op == OP_BEQ) || (op == OP_BNE);
        lw = (op == OP_LW);
        ls = lw || (op == OP_SW);
        cur_n = 0; first_ret = -1;
        for (int i = 0; i < if_w; i++) step(PH_IF, op, z, 1'b0, tag);
        step(PH_IF, op, z, 1'b1, tag);
        step(PH_ID, op, z, rbit(), tag);
        if (cls(op) >= 0) begin
            step(PH_EX, op, z, rbit(), tag);
            if (ls) begin
                for (int i = 0; i < mem_w; i++) step(PH_MEM, op, z, 1'b0, tag);
                step(PH_MEM, op, z, 1'b1, tag);
            end
            if (lw || (!br && !ls)) step(PH_WB, op, z, rbit(), tag);
        end
        dut_cycles = first_ret;
    endtask

    function automatic int latency(logic [5:0] op, int if_w, int mem_w);
        int l;
        l = if_w + 2;
        if (cls(op) >= 0) begin
            l += 1;
            if (op == OP_LW || op == OP_SW) l += mem_w + 1;
            if (op != OP_SW && op != OP_BEQ && op != OP_BNE) l += 1;
        end
        return l;
    endfunction

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         if_w;
        int         mem_w;
        int         cycles;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] known_ops[9] = '{OP_R, OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI, OP_BEQ, OP_BNE,
                                 OP_LW, OP_SW};

    initial begin
        int dc;
        logic [5:0] op;
        int iw, mw;

        vecs.push_back('{OP_R,     1'b0, 0, 0, 4});
        vecs.push_back('{OP_BEQ,   1'b1, 0, 0, 3});
        vecs.push_back('{OP_BNE,   1'b1, 0, 0, 3});
        vecs.push_back('{OP_LW,    1'b0, 2, 3, 10});
        vecs.push_back('{OP_SW,    1'b0, 0, 2, 6});
        vecs.push_back('{OP_ADDI,  1'b0, 0, 0, 4});
        vecs.push_back('{OP_SLTIU, 1'b1, 1, 0, 5});
        vecs.push_back('{OP_ORI,   1'b0, 0, 0, 4});
        vecs.push_back('{OP_LUI,   1'b0, 0, 0, 4});
        vecs.push_back('{OP_BEQ,   1'b0, 0, 0, 3});
        vecs.push_back('{OP_BNE,   1'b0, 3, 0, 6});
`ifndef CTRL_ILLEGAL_TRAP_EN
        vecs.push_back('{OP_BAD,   1'b0, 0, 0, 2});
`endif

        rst_n = 1'b0; instr_op = OP_R; zero = 1'b0; mem_ready = 1'b1; cnt_m = '0;
        #2;
        check_vec("reset outputs", dut_v, 15'd0);
        check_int("reset cnt", int'(retire_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].z, vecs[i].if_w, vecs[i].mem_w,
                      $sformatf("vec%0d", i), dc);
            check_int($sformatf("vec%0d latency", i), dc, vecs[i].cycles);
        end

        // Reset while MEM waits on ready: request drops at once, FSM back in IF.
        cur_n = 0; first_ret = -1;
        step(PH_IF, OP_LW, 1'b0, 1'b1, "rstmem");
        step(PH_ID, OP_LW, 1'b0, 1'b0, "rstmem");
        step(PH_EX, OP_LW, 1'b0, 1'b0, "rstmem");
        step(PH_MEM, OP_LW, 1'b0, 1'b0, "rstmem");
        #1 rst_n = 1'b0;
        #1;
        check_vec("rstmem outputs low", dut_v, 15'd0);
        check_int("rstmem cnt", int'(retire_cnt), 0);
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("rstmem release IF", dut_v, exp_out(PH_IF, OP_LW, 1'b0, 1'b0));

        // Sixteen retires wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            run_instr(OP_R, 1'b0, 0, 0, "wrap", dc);
            if (i == 14) begin
                @(posedge clk); #1;
                check_int("wrap cnt 15", int'(retire_cnt), 15);
            end
        end
        @(posedge clk); #1;
        check_int("wrap cnt 0", int'(retire_cnt), 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
        cur_n = 0; first_ret = -1;
        step(PH_IF, OP_BAD, 1'b0, 1'b1, "trap");
        step(PH_ID, OP_BAD, 1'b0, 1'b0, "trap");
        for (int i = 0; i < 20; i++) step(PH_TRAP, OP_BAD, rbit(), rbit(), "trap");
        check_int("trap no retire", first_ret, -1);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        check_vec("trap reset outputs", dut_v, 15'd0);
        cnt_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        for (int n = 0; n < 60; n++) begin
            op = known_ops[$urandom_range(0, 8)];
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
`endif
            iw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            run_instr(op, rbit(), iw, mw, $sformatf("rnd%0d op%b", n, op), dc);
            check_int($sformatf("rnd%0d latency", n), dc, latency(op, iw, mw));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
